// File: rtl/mfc_ram_controller_pkg.sv
// Shared encodings and helpers for the MFA/MFC byte-addressed RAM controller.
package mfc_ram_controller_pkg;

  localparam logic [1:0] DT_BYTE  = 2'b00;
  localparam logic [1:0] DT_HALF  = 2'b01;
  localparam logic [1:0] DT_WORD  = 2'b10;
  localparam logic       RW_READ  = 1'b0;
  localparam logic       RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  dt;
    logic [31:0] data;
  } req_t;

  function automatic logic [2:0] dt_size(input logic [1:0] dt);
    case (dt)
      DT_BYTE: return 3'd1;
      DT_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Lane 0 is the byte at the request address, lane 3 is address+3.
  function automatic logic [3:0] lane_mask(input logic [1:0] dt);
    case (dt)
      DT_BYTE: return 4'b0001;
      DT_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mfc_byte_array.sv
// DEPTH x 8 storage with a 4-lane byte write port and a 4-byte read port at addr..addr+3.
module mfc_byte_array #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] Mem [0:DEPTH-1];

  logic [3:0][ADDR_W:0] lane_a;
  logic [3:0]           lane_ok;

  always_comb begin
    lane_a  = '0;
    lane_ok = '0;
    for (int i = 0; i < 4; i++) begin
      lane_a[i]  = {1'b0, addr} + (ADDR_W+1)'(i);
      lane_ok[i] = int'(lane_a[i]) < DEPTH;
    end
  end

  // Lanes past the end of storage read as zero and never write.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++)
      if (lane_ok[i]) rdata[31-8*i -: 8] = Mem[lane_a[i][IW-1:0]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i] && lane_ok[i]) Mem[lane_a[i][IW-1:0]] <= wdata[31-8*i -: 8];
  end

endmodule

// File: rtl/mfc_ram_controller.sv
// MFA/MFC handshake RAM: captures a request, checks it, waits LATENCY edges, then accesses.
module mfc_ram_controller
  import mfc_ram_controller_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        DT,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              MFC,
  output logic              FAULT
);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] r_addr;
  req_t              r_req;

  logic        req_bad;
  logic        commit;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] rd_fmt;

  // Reject misaligned, illegal-size and out-of-range requests before any access.
  always_comb begin
    req_bad = 1'b0;
    if (DT == 2'b11)                           req_bad = 1'b1;
    if (DT == DT_HALF && ADDR[0])              req_bad = 1'b1;
    if (DT == DT_WORD && ADDR[1:0] != 2'b00)   req_bad = 1'b1;
    if (int'(ADDR) + int'(dt_size(DT)) - 1 >= DEPTH) req_bad = 1'b1;
  end

  assign commit = (state == ST_BUSY) && (cnt == 4'd0);

  // Sub-word data is right-aligned on the bus but lands at lane 0 (the request address).
  always_comb begin
    we    = (commit && r_req.rw == RW_WRITE) ? lane_mask(r_req.dt) : 4'b0000;
    wdata = r_req.data;
    rd_fmt = rdata;
    case (r_req.dt)
      DT_BYTE: begin
        wdata  = {r_req.data[7:0], 24'h0};
        rd_fmt = {24'h0, rdata[31:24]};
      end
      DT_HALF: begin
        wdata  = {r_req.data[15:0], 16'h0};
        rd_fmt = {16'h0, rdata[31:16]};
      end
      default: ;
    endcase
  end

  mfc_byte_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_arr (
    .clk   (CLK),
    .we    (we),
    .addr  (r_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      MFC      <= 1'b0;
      FAULT    <= 1'b0;
      DATA_OUT <= '0;
      r_addr   <= '0;
      r_req    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (MFA) begin
          r_addr <= ADDR;
          r_req  <= '{rw: RW, dt: DT, data: DATA_IN[31:0]};
          if (req_bad) begin
            state <= ST_DONE;
            MFC   <= 1'b1;
            FAULT <= 1'b1;
          end else begin
            state <= ST_BUSY;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        ST_BUSY: if (cnt == 4'd0) begin
          state <= ST_DONE;
          MFC   <= 1'b1;
          FAULT <= 1'b0;
          if (r_req.rw == RW_READ) DATA_OUT <= DATA_W'(rd_fmt);
        end else begin
          cnt <= cnt - 4'd1;
        end
        ST_DONE: if (!MFA) begin
          state <= ST_IDLE;
          MFC   <= 1'b0;
          FAULT <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
